axi_default_slave: RTL and testbench

AXI_DEFAULT_SLAVE -- requirements
Module: axi_default_slave

---
 rtl/axi_default_slave.sv | 147 ++++++++++++++
 tb/tb_axi_default_slave.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_default_slave.sv
// AXI responder for unmapped address space: accepts one transaction at a time and
// answers with zero read data and OKAY, or DECERR when DS_DECERR_EN is defined.
module axi_default_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [LEN_W-1:0]    AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,

    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,

    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,

    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [LEN_W-1:0]    ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,

    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);

`ifdef DS_DECERR_EN
    localparam logic [1:0] RESP_CODE = 2'b11;
`else
    localparam logic [1:0] RESP_CODE = 2'b00;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RDATA
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [ID_W-1:0]  id_q, id_d;

    // Address, size, burst type, AWLEN and write data are deliberately ignored.
    logic unused_inputs;
    assign unused_inputs = ^{AWADDR, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB,
                             ARADDR, ARSIZE, ARBURST};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        beat_d  = beat_q;
        len_d   = len_q;
        id_d    = id_q;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BID     = '0;
        BRESP   = 2'b00;
        BVALID  = 1'b0;
        ARREADY = 1'b0;
        RID     = '0;
        RDATA   = '0;
        RRESP   = 2'b00;
        RLAST   = 1'b0;
        RVALID  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Ready is combinational, so it is gated by rst; a simultaneous AR wins over AW.
                ARREADY = !rst;
                AWREADY = !rst && !ARVALID;
                if (ARVALID && ARREADY) begin
                    id_d    = ARID;
                    len_d   = ARLEN;
                    beat_d  = '0;
                    state_d = ST_RDATA;
                end else if (AWVALID && AWREADY) begin
                    id_d    = AWID;
                    state_d = ST_WDATA;
                end
            end
            ST_WDATA: begin
                WREADY = 1'b1;
                if (WVALID && WLAST)
                    state_d = ST_WRESP;
            end
            ST_WRESP: begin
                BVALID = 1'b1;
                BID    = id_q;
                BRESP  = RESP_CODE;
                if (BREADY)
                    state_d = ST_IDLE;
            end
            ST_RDATA: begin
                RVALID = 1'b1;
                RID    = id_q;
                RRESP  = RESP_CODE;
                RLAST  = (beat_q == len_q);
                if (RREADY) begin
                    // The counter stops at len_q on the last beat, so ARLEN at max never wraps it.
                    if (RLAST)
                        state_d = ST_IDLE;
                    else
                        beat_d = beat_q + LEN_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            id_q    <= id_d;
        end
    end

endmodule

// File: tb/tb_axi_default_slave.sv
// Directed testbench for axi_default_slave: a cycle-by-cycle vector table plus
// hand-written sequences for a max-length stalled read and reset mid-read.
module tb_axi_default_slave;

`ifdef DS_DECERR_EN
    localparam logic [1:0] EXP_RESP = 2'b11;
`else
    localparam logic [1:0] EXP_RESP = 2'b00;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_default_slave #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
        .clk(clk), .rst(rst),
        .AWID(awid), .AWADDR(awaddr), .AWLEN(awlen), .AWSIZE(awsize), .AWBURST(awburst),
        .AWVALID(awvalid), .AWREADY(awready),
        .WDATA(wdata), .WSTRB(wstrb), .WLAST(wlast), .WVALID(wvalid), .WREADY(wready),
        .BID(bid), .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
        .ARID(arid), .ARADDR(araddr), .ARLEN(arlen), .ARSIZE(arsize), .ARBURST(arburst),
        .ARVALID(arvalid), .ARREADY(arready),
        .RID(rid), .RDATA(rdata), .RRESP(rresp), .RLAST(rlast), .RVALID(rvalid), .RREADY(rready)
    );

    typedef struct {
        logic       arv;  logic [7:0] arid_v; logic [3:0] arlen_v;
        logic       awv;  logic [7:0] awid_v;
        logic       wv;   logic       wl;     logic rr; logic br;
        logic       e_arr, e_awr, e_wr, e_rv, e_rl;
        logic [7:0] e_rid;
        logic       e_bv;
        logic [7:0] e_bid;
    } vec_t;

    function automatic vec_t mk(logic arv, logic [7:0] ai, logic [3:0] al,
                                logic awv, logic [7:0] wi, logic wv, logic wl,
                                logic rr, logic br,
                                logic e_arr, logic e_awr, logic e_wr, logic e_rv,
                                logic e_rl, logic [7:0] e_rid, logic e_bv, logic [7:0] e_bid);
        vec_t t;
        t.arv = arv; t.arid_v = ai; t.arlen_v = al; t.awv = awv; t.awid_v = wi;
        t.wv = wv; t.wl = wl; t.rr = rr; t.br = br;
        t.e_arr = e_arr; t.e_awr = e_awr; t.e_wr = e_wr; t.e_rv = e_rv; t.e_rl = e_rl;
        t.e_rid = e_rid; t.e_bv = e_bv; t.e_bid = e_bid;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        arvalid = t.arv; arid = t.arid_v; arlen = t.arlen_v;
        araddr = $urandom; arsize = 3'd2; arburst = 2'b01;
        awvalid = t.awv; awid = t.awid_v; awlen = 4'd0;
        awaddr = $urandom; awsize = 3'd2; awburst = 2'b01;
        wvalid = t.wv; wlast = t.wl; wdata = $urandom; wstrb = 4'hF;
        rready = t.rr; bready = t.br;
        #1;
        check($sformatf("v%0d arready", idx), 32'(arready), 32'(t.e_arr));
        check($sformatf("v%0d awready", idx), 32'(awready), 32'(t.e_awr));
        check($sformatf("v%0d wready", idx), 32'(wready), 32'(t.e_wr));
        check($sformatf("v%0d rvalid", idx), 32'(rvalid), 32'(t.e_rv));
        check($sformatf("v%0d rlast", idx), 32'(rlast), 32'(t.e_rl));
        check($sformatf("v%0d bvalid", idx), 32'(bvalid), 32'(t.e_bv));
        check($sformatf("v%0d rdata", idx), rdata, 32'd0);
        if (t.e_rv) begin
            check($sformatf("v%0d rid", idx), 32'(rid), 32'(t.e_rid));
            check($sformatf("v%0d rresp", idx), 32'(rresp), 32'(EXP_RESP));
        end
        if (t.e_bv) begin
            check($sformatf("v%0d bid", idx), 32'(bid), 32'(t.e_bid));
            check($sformatf("v%0d bresp", idx), 32'(bresp), 32'(EXP_RESP));
        end
    endtask

    vec_t vecs[$];

    initial begin
        //            arv arid  arl awv awid  wv wl rr br | arr awr wr rv rl rid   bv bid
        // Read ARID=15 ARLEN=3: four beats, RLAST on the fourth, then idle.
        vecs.push_back(mk(1, 8'h15, 3, 0, 8'h00, 0, 0, 1, 0,  1, 0, 0, 0, 0, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0,  0, 0, 0, 1, 0, 8'h15, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0,  0, 0, 0, 1, 0, 8'h15, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0,  0, 0, 0, 1, 0, 8'h15, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0,  0, 0, 0, 1, 1, 8'h15, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  1, 1, 0, 0, 0, 8'h00, 0, 8'h00));
        // Write AWID=2A (AWLEN=0 but two beats), one stall, BREADY low three cycles.
        vecs.push_back(mk(0, 8'h00, 0, 1, 8'h2A, 0, 0, 0, 0,  1, 1, 0, 0, 0, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0,  0, 0, 1, 0, 0, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 0, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 0,  0, 0, 1, 0, 0, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 8'h00, 1, 8'h2A));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 8'h00, 1, 8'h2A));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 8'h00, 1, 8'h2A));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1,  0, 0, 0, 0, 0, 8'h00, 1, 8'h2A));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  1, 1, 0, 0, 0, 8'h00, 0, 8'h00));
        // AR and AW together: read first, AW held and accepted afterwards.
        vecs.push_back(mk(1, 8'h01, 0, 1, 8'h02, 0, 0, 1, 0,  1, 0, 0, 0, 0, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 1, 8'h02, 0, 0, 1, 0,  0, 0, 0, 1, 1, 8'h01, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 1, 8'h02, 0, 0, 0, 0,  1, 1, 0, 0, 0, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 0,  0, 0, 1, 0, 0, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1,  0, 0, 0, 0, 0, 8'h00, 1, 8'h02));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  1, 1, 0, 0, 0, 8'h00, 0, 8'h00));

        idle_inputs();
        rst = 1'b1;

        // Reset state: everything low and zero, even with ARVALID low.
        @(negedge clk);
        #1;
        check("rst arready", 32'(arready), 32'd0);
        check("rst awready", 32'(awready), 32'd0);
        check("rst wready", 32'(wready), 32'd0);
        check("rst bvalid", 32'(bvalid), 32'd0);
        check("rst rvalid", 32'(rvalid), 32'd0);
        check("rst rlast", 32'(rlast), 32'd0);
        check("rst ids", 32'({bid, rid}), 32'd0);
        check("rst resp", 32'({bresp, rresp}), 32'd0);
        check("rst rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst arready", 32'(arready), 32'd1);

        foreach (vecs[i]) apply(vecs[i], i);

        // ARLEN=15 with RREADY toggling: 16 handshakes, stable outputs while stalled.
        begin
            int hs = 0;
            int cyc = 0;
            @(negedge clk);
            idle_inputs();
            arvalid = 1'b1; arid = 8'h3C; arlen = 4'd15;
            #1;
            check("long ar handshake", 32'(arready), 32'd1);
            while (hs < 16 && cyc < 64) begin
                @(negedge clk);
                arvalid = 1'b0;
                rready  = cyc[0];
                #1;
                check($sformatf("long c%0d rvalid", cyc), 32'(rvalid), 32'd1);
                check($sformatf("long c%0d rid", cyc), 32'(rid), 32'h3C);
                check($sformatf("long c%0d rlast", cyc), 32'(rlast), 32'(hs == 15));
                check($sformatf("long c%0d rdata", cyc), rdata, 32'd0);
                check($sformatf("long c%0d rresp", cyc), 32'(rresp), 32'(EXP_RESP));
                if (rvalid && rready) hs++;
                cyc++;
            end
            check("long handshakes", 32'(hs), 32'd16);
            @(negedge clk);
            rready = 1'b0;
            #1;
            check("long end rvalid", 32'(rvalid), 32'd0);
            check("long end arready", 32'(arready), 32'd1);
        end

        // Reset asserted during beat 2 of a 4-beat read.
        @(negedge clk);
        arvalid = 1'b1; arid = 8'h77; arlen = 4'd3; rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        #1;
        check("mid beat2 rvalid", 32'(rvalid), 32'd1);
        check("mid beat2 rlast", 32'(rlast), 32'd0);
        rst = 1'b1;
        #1;
        check("mid rst rvalid", 32'(rvalid), 32'd0);
        check("mid rst rid", 32'(rid), 32'd0);
        check("mid rst rresp", 32'(rresp), 32'd0);
        check("mid rst arready", 32'(arready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid release arready", 32'(arready), 32'd1);
        check("mid release rvalid", 32'(rvalid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("mid residual %0d rvalid", k), 32'(rvalid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
